// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: run/step/drain FSM, load-use stall and branch flush
// generation, plus saturating run and stall counters.
module pipeline_ctrl #(
    parameter int unsigned NB_REG       = 5,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned NB_CNT       = 32
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic              mode_step_i,
    input  logic              step_i,
    input  logic              halt_detected_i,
    input  logic              idex_mem_read_i,
    input  logic [NB_REG-1:0] idex_rt_i,
    input  logic [NB_REG-1:0] ifid_rs_i,
    input  logic [NB_REG-1:0] ifid_rt_i,
    input  logic              branch_taken_i,
    output logic              enable_pc_o,
    output logic              enable_ifid_o,
    output logic              enable_pipe_o,
    output logic              bubble_idex_o,
    output logic              flush_ifid_o,
    output logic [2:0]        state_o,
    output logic              done_o,
    output logic [NB_CNT-1:0] cycle_count_o,
    output logic [15:0]       stall_count_o
);

    localparam int unsigned NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [NB_DRAIN-1:0] DRAIN_LAST = NB_DRAIN'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRun   = 3'd1,
        StStep  = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_step_q;
    logic [NB_DRAIN-1:0] r_drain_cnt;
    logic [NB_CNT-1:0]   r_cycle_cnt;
    logic [15:0]         r_stall_cnt;

    logic w_step_edge;
    logic w_advance;
    logic w_reg_match;
    logic w_hazard;

    assign w_step_edge = step_i & ~r_step_q;
    assign w_advance   = (r_state == StRun) | ((r_state == StStep) & w_step_edge) |
                         (r_state == StDrain);
    assign w_reg_match = (idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i);
    // Draining only flushes what is already in flight, so it never stalls on a load-use.
    assign w_hazard    = w_advance & (r_state != StDrain) & idex_mem_read_i &
                         (idex_rt_i != '0) & w_reg_match;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= StIdle;
            r_step_q    <= 1'b0;
            r_drain_cnt <= '0;
        end else begin
            r_step_q <= step_i;
            case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_state <= mode_step_i ? StStep : StRun;
                    end
                end
                StRun: begin
                    if (halt_detected_i) begin
                        r_state     <= StDrain;
                        r_drain_cnt <= '0;
                    end
                end
                StStep: begin
                    if (w_step_edge && halt_detected_i) begin
                        r_state     <= StDrain;
                        r_drain_cnt <= '0;
                    end
                end
                StDrain: begin
                    r_drain_cnt <= r_drain_cnt + 1'b1;
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state <= StDone;
                    end
                end
                StDone: r_state <= StDone;
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (enable_pipe_o && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            if (w_hazard && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // A hazard or drain freezes fetch and injects a bubble; a pending branch is re-seen later.
    always_comb begin
        enable_pc_o   = 1'b0;
        enable_ifid_o = 1'b0;
        enable_pipe_o = 1'b0;
        bubble_idex_o = 1'b0;
        flush_ifid_o  = 1'b0;
        if (w_advance) begin
            enable_pipe_o = 1'b1;
            if ((r_state == StDrain) || w_hazard) begin
                bubble_idex_o = 1'b1;
            end else begin
                enable_pc_o   = 1'b1;
                enable_ifid_o = 1'b1;
                flush_ifid_o  = branch_taken_i;
            end
        end
    end

    assign state_o       = r_state;
    assign done_o        = (r_state == StDone);
    assign cycle_count_o = r_cycle_cnt;
    assign stall_count_o = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_pipeline_ctrl;

    localparam int DRAIN = 3;

    logic        clk;
    logic        rst_n;
    logic        start, mode, step, halt, mr, br;
    logic [4:0]  rt_x, rs_d, rt_d;
    logic        en_pc, en_ifid, en_pipe, bubble, flush, done;
    logic [2:0]  state;
    logic [31:0] cyc_cnt;
    logic [15:0] stall_cnt;

    int checks;
    int failures;

    // Behavioural model: mode 0 idle, 1 run, 2 step, 3 drain, 4 done.
    int     m_state;
    bit     m_step_prev;
    int     m_drain_left;
    longint m_cyc;
    int     m_stall;

    pipeline_ctrl dut (
        .clock_i        (clk),
        .reset_n_i      (rst_n),
        .start_i        (start),
        .mode_step_i    (mode),
        .step_i         (step),
        .halt_detected_i(halt),
        .idex_mem_read_i(mr),
        .idex_rt_i      (rt_x),
        .ifid_rs_i      (rs_d),
        .ifid_rt_i      (rt_d),
        .branch_taken_i (br),
        .enable_pc_o    (en_pc),
        .enable_ifid_o  (en_ifid),
        .enable_pipe_o  (en_pipe),
        .bubble_idex_o  (bubble),
        .flush_ifid_o   (flush),
        .state_o        (state),
        .done_o         (done),
        .cycle_count_o  (cyc_cnt),
        .stall_count_o  (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit m_adv();
        return (m_state == 1) || (m_state == 2 && step && !m_step_prev) || (m_state == 3);
    endfunction

    function automatic bit m_haz();
        return m_adv() && m_state != 3 && mr && rt_x != 0 && (rt_x == rs_d || rt_x == rt_d);
    endfunction

    // Expected {pc, ifid, pipe, bubble, flush}.
    function automatic logic [4:0] exp_ctrl();
        if (!m_adv()) return 5'b00000;
        if (m_state == 3 || m_haz()) return 5'b00110;
        return {4'b1110, br};
    endfunction

    task automatic model_reset();
        m_state      = 0;
        m_step_prev  = 1'b0;
        m_drain_left = 0;
        m_cyc        = 0;
        m_stall      = 0;
    endtask

    task automatic clear_inputs();
        start = 0; mode = 0; step = 0; halt = 0; mr = 0; br = 0;
        rt_x = 0; rs_d = 0; rt_d = 0;
    endtask

    // Advance one clock; inputs are held stable across the edge.
    task automatic tick();
        bit edge_s;
        @(posedge clk);
        edge_s = step && !m_step_prev;
        if (m_adv() && m_cyc != 64'hFFFF_FFFF) m_cyc++;
        if (m_haz() && m_stall != 65535) m_stall++;
        case (m_state)
            0: if (start) m_state = mode ? 2 : 1;
            1: if (halt) begin m_state = 3; m_drain_left = DRAIN; end
            2: if (edge_s && halt) begin m_state = 3; m_drain_left = DRAIN; end
            3: begin
                m_drain_left--;
                if (m_drain_left == 0) m_state = 4;
            end
            default: ;
        endcase
        m_step_prev = step;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        start = 1;
        tick();
        tick();
        #2 rst_n = 0;
        #1;
        checks++;
        if (state !== 3'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: state=%0d done=%0b want 0/0", state, done);
        end
        checks++;
        if ({en_pc, en_ifid, en_pipe, bubble, flush} !== 5'b0) begin
            failures++;
            $display("FAIL reset_enables: got %b want 00000",
                     {en_pc, en_ifid, en_pipe, bubble, flush});
        end
        checks++;
        if (cyc_cnt !== 32'd0 || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: cyc=%0d stall=%0d want 0/0", cyc_cnt, stall_cnt);
        end
        do_reset();
        tick();
        #3;
        checks++;
        if (state !== 3'd0 || en_pipe !== 1'b0) begin
            failures++;
            $display("FAIL reset_wait_start: state=%0d pipe=%0b want 0/0", state, en_pipe);
        end
        tick();
    endtask

    task automatic test_continuous();
        int npipe;
        npipe = 0;
        do_reset();
        start = 1;
        #3;
        checks++;
        if (en_pipe !== 1'b0) begin
            failures++;
            $display("FAIL cont_idle_pipe: got %0b want 0", en_pipe);
        end
        tick();
        start = 0;
        for (int i = 1; i <= 13; i++) begin
            halt = (i == 10);
            #3;
            npipe += int'(en_pipe);
            checks++;
            if ({en_pc, en_ifid, en_pipe, bubble, flush} !== exp_ctrl()) begin
                failures++;
                $display("FAIL cont_ctrl cycle %0d: got %b want %b", i,
                         {en_pc, en_ifid, en_pipe, bubble, flush}, exp_ctrl());
            end
            tick();
        end
        halt = 0;
        #3;
        checks++;
        if (state !== 3'd4 || done !== 1'b1 || cyc_cnt !== 32'd13 || npipe != 13) begin
            failures++;
            $display("FAIL cont_done: state=%0d done=%0b cyc=%0d pipes=%0d want 4/1/13/13",
                     state, done, cyc_cnt, npipe);
        end
        start = 1;
        tick();
        tick();
        #3;
        checks++;
        if (state !== 3'd4 || cyc_cnt !== 32'd13 || en_pipe !== 1'b0) begin
            failures++;
            $display("FAIL done_terminal: state=%0d cyc=%0d pipe=%0b want 4/13/0",
                     state, cyc_cnt, en_pipe);
        end
        start = 0;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        start = 1;
        tick();
        start = 0;
        mr = 1; rt_x = 5; rs_d = 5; rt_d = 7;
        #3;
        checks++;
        if ({en_pc, en_ifid, en_pipe, bubble, flush} !== 5'b00110) begin
            failures++;
            $display("FAIL loaduse_rs: got %b want 00110",
                     {en_pc, en_ifid, en_pipe, bubble, flush});
        end
        tick();
        mr = 1; rt_x = 0; rs_d = 0; rt_d = 0;
        #3;
        checks++;
        if (stall_cnt !== 16'd1 || en_pc !== 1'b1 || bubble !== 1'b0) begin
            failures++;
            $display("FAIL loaduse_r0: stall=%0d pc=%0b bubble=%0b want 1/1/0",
                     stall_cnt, en_pc, bubble);
        end
        tick();
        mr = 1; rt_x = 3; rs_d = 9; rt_d = 3;
        #3;
        checks++;
        if (en_pc !== 1'b0 || bubble !== 1'b1) begin
            failures++;
            $display("FAIL loaduse_rt: pc=%0b bubble=%0b want 0/1", en_pc, bubble);
        end
        tick();
        mr = 0;
        #3;
        checks++;
        if (stall_cnt !== 16'd2 || en_pc !== 1'b1) begin
            failures++;
            $display("FAIL loaduse_noread: stall=%0d pc=%0b want 2/1", stall_cnt, en_pc);
        end
        tick();
    endtask

    task automatic test_step();
        logic [8:0] seq;
        int npipe;
        seq = 9'b0_1010_1111;
        npipe = 0;
        do_reset();
        start = 1; mode = 1;
        tick();
        start = 0; mode = 0;
        for (int i = 0; i < 9; i++) begin
            step = seq[i];
            #3;
            npipe += int'(en_pipe);
            checks++;
            if ({en_pc, en_ifid, en_pipe, bubble, flush} !== exp_ctrl()) begin
                failures++;
                $display("FAIL step_ctrl cycle %0d: got %b want %b", i,
                         {en_pc, en_ifid, en_pipe, bubble, flush}, exp_ctrl());
            end
            tick();
        end
        step = 0;
        #3;
        checks++;
        if (npipe != 3 || cyc_cnt !== 32'd3 || state !== 3'd2) begin
            failures++;
            $display("FAIL step_count: pipes=%0d cyc=%0d state=%0d want 3/3/2",
                     npipe, cyc_cnt, state);
        end
        tick();
    endtask

    task automatic test_branch_hazard();
        do_reset();
        start = 1;
        tick();
        start = 0;
        br = 1; mr = 1; rt_x = 4; rs_d = 4;
        #3;
        checks++;
        if (flush !== 1'b0 || bubble !== 1'b1) begin
            failures++;
            $display("FAIL br_haz: flush=%0b bubble=%0b want 0/1", flush, bubble);
        end
        tick();
        mr = 0;
        #3;
        checks++;
        if (flush !== 1'b1 || bubble !== 1'b0 || en_pc !== 1'b1) begin
            failures++;
            $display("FAIL br_only: flush=%0b bubble=%0b pc=%0b want 1/0/1", flush, bubble, en_pc);
        end
        tick();
        br = 0; mr = 1; halt = 1;
        #3;
        checks++;
        if (en_pc !== 1'b0 || bubble !== 1'b1) begin
            failures++;
            $display("FAIL halt_haz: pc=%0b bubble=%0b want 0/1", en_pc, bubble);
        end
        tick();
        halt = 0; br = 1;
        #3;
        checks++;
        if (state !== 3'd3 || stall_cnt !== 16'd2 || flush !== 1'b0 || bubble !== 1'b1) begin
            failures++;
            $display("FAIL drain_outputs: state=%0d stall=%0d flush=%0b bubble=%0b want 3/2/0/1",
                     state, stall_cnt, flush, bubble);
        end
        tick();
        #3;
        checks++;
        if (stall_cnt !== 16'd2) begin
            failures++;
            $display("FAIL drain_nostall: stall=%0d want 2", stall_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        start = 1;
        tick();
        start = 0; halt = 1;
        tick();
        halt = 0;
        tick();
        #2 rst_n = 0;
        #1;
        checks++;
        if (state !== 3'd0 || cyc_cnt !== 32'd0 || stall_cnt !== 16'd0 || done !== 1'b0 ||
            en_pipe !== 1'b0) begin
            failures++;
            $display("FAIL drain_reset: state=%0d cyc=%0d stall=%0d done=%0b pipe=%0b want 0",
                     state, cyc_cnt, stall_cnt, done, en_pipe);
        end
        do_reset();
        start = 1;
        tick();
        start = 0;
        tick();
        halt = 1;
        tick();
        halt = 0;
        repeat (3) tick();
        #3;
        checks++;
        if (state !== 3'd4 || cyc_cnt !== 32'd5 || done !== 1'b1) begin
            failures++;
            $display("FAIL restart_done: state=%0d cyc=%0d done=%0b want 4/5/1",
                     state, cyc_cnt, done);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ((m_state == 4 && $urandom_range(0, 7) == 0) || (i % 400 == 399)) do_reset();
            start = ($urandom_range(0, 3) == 0);
            mode  = $urandom_range(0, 1);
            step  = $urandom_range(0, 1);
            halt  = ($urandom_range(0, 24) == 0);
            mr    = $urandom_range(0, 1);
            br    = $urandom_range(0, 1);
            rt_x  = 5'($urandom_range(0, 3));
            rs_d  = 5'($urandom_range(0, 3));
            rt_d  = 5'($urandom_range(0, 3));
            #3;
            checks++;
            if ({en_pc, en_ifid, en_pipe, bubble, flush} !== exp_ctrl() ||
                state !== 3'(m_state) || done !== (m_state == 4)) begin
                failures++;
                $display("FAIL rand_ctrl cycle %0d: ctrl=%b st=%0d done=%0b want %b/%0d/%0b", i,
                         {en_pc, en_ifid, en_pipe, bubble, flush}, state, done, exp_ctrl(),
                         m_state, m_state == 4);
            end
            checks++;
            if (cyc_cnt !== m_cyc[31:0] || stall_cnt !== 16'(m_stall)) begin
                failures++;
                $display("FAIL rand_counts cycle %0d: cyc=%0d stall=%0d want %0d/%0d", i,
                         cyc_cnt, stall_cnt, m_cyc, m_stall);
            end
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 0;
        clear_inputs();
        model_reset();
        test_reset();
        test_continuous();
        test_load_use();
        test_step();
        test_branch_hazard();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
